// File: rtl/aq_axis_reduce_ctrl_if.sv
// AXI4-Lite write-only channel bundle between the reduce job controller
// and the aq_axis_reduce core register port.
interface aq_axis_reduce_ctrl_if;
   logic [31:0] awaddr;
   logic [3:0]  awcache;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic        bvalid;
   logic        bready;
   logic [1:0]  bresp;

   modport master (
      output awaddr, awcache, awprot, awvalid,
      output wdata, wstrb, wvalid, bready,
      input  awready, wready, bvalid, bresp
   );

   modport slave (
      input  awaddr, awcache, awprot, awvalid,
      input  wdata, wstrb, wvalid, bready,
      output awready, wready, bvalid, bresp
   );
endinterface

// File: rtl/aq_axis_reduce_ctrl.sv
// Job controller for aq_axis_reduce: programs ORG/CNV sizes, then runs frames.
// Optional AQ_REDUCE_CTRL_RECFG_EN rewrites both size registers between frames.
module aq_axis_reduce_ctrl #(
   parameter logic [23:0] TIMEOUT = 24'd1_000_000
) (
   input  logic        ACLK,
   input  logic        ARESET,
   input  logic        START,
   input  logic        STOP,
   input  logic [15:0] ORG_X,
   input  logic [15:0] ORG_Y,
   input  logic [15:0] CNV_X,
   input  logic [15:0] CNV_Y,
   input  logic [15:0] FRAMES,
   aq_axis_reduce_ctrl_if.master m_axi,
   output logic        FSYNC_IN,
   input  logic        FSYNC_OUT,
   output logic        BUSY,
   output logic        DONE,
   output logic        ERR,
   output logic [15:0] FRAME_CNT
);

   localparam logic [31:0] REG_ORG = 32'h0000_0000;
   localparam logic [31:0] REG_CNV = 32'h0000_0004;

   typedef enum logic [2:0] {
      IDLE, WR_REQ, WR_RESP, FSYNC, WAIT_FS, FIN
   } state_t;

   state_t      state_q, state_d;
   logic        awv_q, awv_d, wv_q, wv_d;
   logic        bready_q, bready_d;
   logic        fsync_q, fsync_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic        busy_q;
   logic        stop_q, stop_d;
   logic        sel_q, sel_d;
   logic        fs_q1, fs_q2;
   logic [31:0] addr_q, addr_d, data_q, data_d;
   logic [31:0] org_q, org_d, cnv_q, cnv_d;
   logic [15:0] frames_q, frames_d, cnt_q, cnt_d;
   logic [23:0] wd_q, wd_d;
   logic        fs_edge, stop_now;

   assign fs_edge  = fs_q1 & ~fs_q2;
   assign stop_now = stop_q | STOP;

   always_comb begin
      state_d  = state_q;
      awv_d    = awv_q;
      wv_d     = wv_q;
      bready_d = 1'b0;
      fsync_d  = 1'b0;
      done_d   = 1'b0;
      err_d    = err_q;
      sel_d    = sel_q;
      addr_d   = addr_q;
      data_d   = data_q;
      org_d    = org_q;
      cnv_d    = cnv_q;
      frames_d = frames_q;
      cnt_d    = cnt_q;
      wd_d     = '0;
      stop_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (START) begin
               org_d    = {ORG_Y, ORG_X};
               cnv_d    = {CNV_Y, CNV_X};
               frames_d = FRAMES;
               err_d    = 1'b0;
               cnt_d    = '0;
               sel_d    = 1'b0;
               addr_d   = REG_ORG;
               data_d   = {ORG_Y, ORG_X};
               awv_d    = 1'b1;
               wv_d     = 1'b1;
               state_d  = WR_REQ;
            end
         end
         WR_REQ: begin
            awv_d = awv_q & ~m_axi.awready;
            wv_d  = wv_q & ~m_axi.wready;
            if (!awv_d && !wv_d) begin
               bready_d = 1'b1;
               state_d  = WR_RESP;
            end
         end
         WR_RESP: begin
            bready_d = 1'b1;
            if (m_axi.bvalid) begin
               bready_d = 1'b0;
               if (m_axi.bresp != 2'b00) begin
                  err_d   = 1'b1;
                  done_d  = 1'b1;
                  state_d = FIN;
               end else if (!sel_q) begin
                  sel_d   = 1'b1;
                  addr_d  = REG_CNV;
                  data_d  = cnv_q;
                  awv_d   = 1'b1;
                  wv_d    = 1'b1;
                  state_d = WR_REQ;
               end else if (stop_now) begin
                  done_d  = 1'b1;
                  state_d = FIN;
               end else begin
                  fsync_d = 1'b1;
                  state_d = FSYNC;
               end
            end
         end
         // The stop check is made on the way in, so FSYNC_IN is already out.
         FSYNC: state_d = WAIT_FS;
         WAIT_FS: begin
            wd_d = wd_q + 24'd1;
            if (fs_edge) begin
               cnt_d = cnt_q + 16'd1;
               if ((frames_q != 16'd0 && cnt_d == frames_q) || stop_now) begin
                  done_d  = 1'b1;
                  state_d = FIN;
               end else begin
`ifdef AQ_REDUCE_CTRL_RECFG_EN
                  org_d   = {ORG_Y, ORG_X};
                  cnv_d   = {CNV_Y, CNV_X};
                  sel_d   = 1'b0;
                  addr_d  = REG_ORG;
                  data_d  = {ORG_Y, ORG_X};
                  awv_d   = 1'b1;
                  wv_d    = 1'b1;
                  state_d = WR_REQ;
`else
                  fsync_d = 1'b1;
                  state_d = FSYNC;
`endif
               end
            end else if (wd_q == TIMEOUT - 24'd1) begin
               err_d   = 1'b1;
               done_d  = 1'b1;
               state_d = FIN;
            end
         end
         FIN: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (state_q != IDLE && state_d != IDLE)
         stop_d = stop_now;
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q  <= IDLE;
         awv_q    <= 1'b0;
         wv_q     <= 1'b0;
         bready_q <= 1'b0;
         fsync_q  <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         busy_q   <= 1'b0;
         stop_q   <= 1'b0;
         sel_q    <= 1'b0;
         fs_q1    <= 1'b0;
         fs_q2    <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         org_q    <= '0;
         cnv_q    <= '0;
         frames_q <= '0;
         cnt_q    <= '0;
         wd_q     <= '0;
      end else begin
         state_q  <= state_d;
         awv_q    <= awv_d;
         wv_q     <= wv_d;
         bready_q <= bready_d;
         fsync_q  <= fsync_d;
         done_q   <= done_d;
         err_q    <= err_d;
         busy_q   <= (state_d != IDLE);
         stop_q   <= stop_d;
         sel_q    <= sel_d;
         fs_q1    <= FSYNC_OUT;
         fs_q2    <= fs_q1;
         addr_q   <= addr_d;
         data_q   <= data_d;
         org_q    <= org_d;
         cnv_q    <= cnv_d;
         frames_q <= frames_d;
         cnt_q    <= cnt_d;
         wd_q     <= wd_d;
      end
   end

   assign m_axi.awaddr  = addr_q;
   assign m_axi.awcache = 4'b0011;
   assign m_axi.awprot  = 3'b000;
   assign m_axi.awvalid = awv_q;
   assign m_axi.wdata   = data_q;
   assign m_axi.wstrb   = 4'hF;
   assign m_axi.wvalid  = wv_q;
   assign m_axi.bready  = bready_q;

   assign FSYNC_IN  = fsync_q;
   assign BUSY      = busy_q;
   assign DONE      = done_q;
   assign ERR       = err_q;
   assign FRAME_CNT = cnt_q;

endmodule
